// File: rtl/dmem_access_ctrl.sv
// Request/response front end for the synchronous distributed data RAM.
// state | meaning: INIT qspo reset | IDLE accept | RD ce pulse | WAIT qspo valid | WR we pulse | RESP hold response
module dmem_access_ctrl #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 6,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  output logic              ram_we,
  output logic              ram_qspo_ce,
  output logic              ram_qspo_srst,
  input  logic [DATA_W-1:0] ram_qspo
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } state_t;

  state_t            state, state_nxt;
  logic              req_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic [ADDR_W-1:0] ram_a_nxt;
  logic [DATA_W-1:0] ram_d_nxt;
  logic              ram_we_nxt, ram_qspo_ce_nxt, ram_qspo_srst_nxt;
  logic              op_we, op_we_nxt;
  logic [DATA_W-1:0] op_wdata, op_wdata_nxt;
  logic [BE_W-1:0]   op_be, op_be_nxt;
  logic [DATA_W-1:0] be_mask;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < BE_W; i++) begin
      be_mask[i*8 +: 8] = {8{op_be[i]}};
    end
  end

  always_comb begin
    state_nxt         = state;
    req_ready_nxt     = req_ready;
    rsp_valid_nxt     = rsp_valid;
    rsp_rdata_nxt     = rsp_rdata;
    ram_a_nxt         = ram_a;
    ram_d_nxt         = ram_d;
    ram_we_nxt        = ram_we;
    ram_qspo_ce_nxt   = ram_qspo_ce;
    ram_qspo_srst_nxt = ram_qspo_srst;
    op_we_nxt         = op_we;
    op_wdata_nxt      = op_wdata;
    op_be_nxt         = op_be;
    case (state)
      S_INIT: begin
        ram_qspo_srst_nxt = 1'b0;
        req_ready_nxt     = 1'b1;
        state_nxt         = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid && req_ready) begin
          req_ready_nxt = 1'b0;
          op_we_nxt     = req_we;
          op_wdata_nxt  = req_wdata;
          op_be_nxt     = req_be;
          ram_a_nxt     = req_addr;
          if (req_we && req_be == '0) begin
            rsp_rdata_nxt = '0;
            rsp_valid_nxt = 1'b1;
            state_nxt     = S_RESP;
          end else if (req_we && req_be == '1) begin
            ram_d_nxt  = req_wdata;
            ram_we_nxt = 1'b1;
            state_nxt  = S_WR;
          end else begin
            // reads and partial writes both need the current word first
            ram_qspo_ce_nxt = 1'b1;
            state_nxt       = S_RD;
          end
        end
      end
      S_RD: begin
        ram_qspo_ce_nxt = 1'b0;
        state_nxt       = S_WAIT;
      end
      S_WAIT: begin
        if (op_we) begin
          ram_d_nxt  = (ram_qspo & ~be_mask) | (op_wdata & be_mask);
          ram_we_nxt = 1'b1;
          state_nxt  = S_WR;
        end else begin
          rsp_rdata_nxt = ram_qspo;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RESP;
        end
      end
      S_WR: begin
        ram_we_nxt    = 1'b0;
        rsp_rdata_nxt = ram_d;
        rsp_valid_nxt = 1'b1;
        state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_INIT;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      ram_a         <= '0;
      ram_d         <= '0;
      ram_we        <= 1'b0;
      ram_qspo_ce   <= 1'b0;
      ram_qspo_srst <= 1'b1;
      op_we         <= 1'b0;
      op_wdata      <= '0;
      op_be         <= '0;
    end else begin
      state         <= state_nxt;
      req_ready     <= req_ready_nxt;
      rsp_valid     <= rsp_valid_nxt;
      rsp_rdata     <= rsp_rdata_nxt;
      ram_a         <= ram_a_nxt;
      ram_d         <= ram_d_nxt;
      ram_we        <= ram_we_nxt;
      ram_qspo_ce   <= ram_qspo_ce_nxt;
      ram_qspo_srst <= ram_qspo_srst_nxt;
      op_we         <= op_we_nxt;
      op_wdata      <= op_wdata_nxt;
      op_be         <= op_be_nxt;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl with a behavioural synchronous RAM.
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [5:0]  ram_a;
  logic [31:0] ram_d;
  logic        ram_we, ram_qspo_ce, ram_qspo_srst;
  logic [31:0] ram_qspo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cnt = 0;
  int ce_cnt = 0;
  int overlap_cnt = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] sb [$];

  dmem_access_ctrl #(.DATA_W(32), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
    .ram_qspo_ce(ram_qspo_ce), .ram_qspo_srst(ram_qspo_srst), .ram_qspo(ram_qspo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Distributed RAM with registered read port.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    if (ram_qspo_srst) ram_qspo <= '0;
    else if (ram_qspo_ce) ram_qspo <= mem[ram_a];
  end

  always @(negedge clk) begin
    if (ram_we) we_cnt <= we_cnt + 1;
    if (ram_qspo_ce) ce_cnt <= ce_cnt + 1;
    if (ram_we && ram_qspo_ce) overlap_cnt <= overlap_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output int acc_cyc);
    int n;
    logic [31:0] exp_w;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout got=%b want=1", req_ready);
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    if (!we) exp_w = ref_mem[addr];
    else if (be == 4'h0) exp_w = '0;
    else begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[addr][i*8 +: 8] = wdata[i*8 +: 8];
      exp_w = ref_mem[addr];
    end
    sb.push_back(exp_w);
  endtask

  task automatic wait_rsp(output logic [31:0] data, output int seen_cyc);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (rsp_valid !== 1'b1) begin
      checks++; failures++;
      $display("FAIL rsp_valid_timeout got=%b want=1", rsp_valid);
    end
    data = rsp_rdata;
    seen_cyc = cyc;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h want=0", rsp_rdata); end
    checks++; if (ram_a !== 6'h0) begin failures++; $display("FAIL rst_ram_a got=%h want=0", ram_a); end
    checks++; if (ram_d !== 32'h0) begin failures++; $display("FAIL rst_ram_d got=%h want=0", ram_d); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%b want=0", ram_we); end
    checks++; if (ram_qspo_ce !== 1'b0) begin failures++; $display("FAIL rst_ce got=%b want=0", ram_qspo_ce); end
    checks++; if (ram_qspo_srst !== 1'b1) begin failures++; $display("FAIL rst_srst got=%b want=1", ram_qspo_srst); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ram_qspo_srst !== 1'b1) begin failures++; $display("FAIL init_srst got=%b want=1", ram_qspo_srst); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL init_req_ready got=%b want=0", req_ready); end
    @(posedge clk); #1;
    checks++; if (ram_qspo_srst !== 1'b0) begin failures++; $display("FAIL idle_srst got=%b want=0", ram_qspo_srst); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_full_write();
    int acc, seen, we0;
    logic [31:0] d, e;
    we0 = we_cnt;
    do_req(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, acc);
    checks++; if (ram_we !== 1'b1 || ram_a !== 6'd5 || ram_d !== 32'hDEADBEEF) begin
      failures++; $display("FAIL fw_ram_pins got we=%b a=%0d d=%h want we=1 a=5 d=deadbeef", ram_we, ram_a, ram_d);
    end
    wait_rsp(d, seen);
    checks++; if (seen - acc != 1) begin failures++; $display("FAIL fw_latency got=%0d want=1", seen - acc); end
    e = sb.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL fw_rdata got=%h want=%h", d, e); end
    handshake();
    checks++; if (we_cnt - we0 != 1) begin failures++; $display("FAIL fw_we_cycles got=%0d want=1", we_cnt - we0); end
  endtask

  task automatic test_read(input logic [5:0] addr, input string tag);
    int acc, seen, ce0;
    logic [31:0] d, e;
    ce0 = ce_cnt;
    do_req(1'b0, addr, 32'h0, 4'h0, acc);
    checks++; if (ram_qspo_ce !== 1'b1 || ram_we !== 1'b0 || ram_a !== addr) begin
      failures++; $display("FAIL %s_rd_pins got ce=%b we=%b a=%0d want ce=1 we=0 a=%0d", tag, ram_qspo_ce, ram_we, ram_a, addr);
    end
    wait_rsp(d, seen);
    checks++; if (seen - acc != 2) begin failures++; $display("FAIL %s_rd_latency got=%0d want=2", tag, seen - acc); end
    e = sb.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL %s_rd_data got=%h want=%h", tag, d, e); end
    handshake();
    checks++; if (ce_cnt - ce0 != 1) begin failures++; $display("FAIL %s_ce_cycles got=%0d want=1", tag, ce_cnt - ce0); end
  endtask

  task automatic test_partial_write();
    int acc, seen;
    logic [31:0] d, e;
    do_req(1'b1, 6'd5, 32'h00001122, 4'b0011, acc);
    wait_rsp(d, seen);
    checks++; if (seen - acc != 3) begin failures++; $display("FAIL pw_latency got=%0d want=3", seen - acc); end
    e = sb.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL pw_rdata got=%h want=%h", d, e); end
    handshake();
    checks++; if (mem[5] !== ref_mem[5]) begin failures++; $display("FAIL pw_ram_word got=%h want=%h", mem[5], ref_mem[5]); end
  endtask

  task automatic test_backpressure();
    int acc, seen;
    logic [31:0] d, e;
    do_req(1'b0, 6'd5, 32'h0, 4'h0, acc);
    wait_rsp(d, seen);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== e || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold got valid=%b rdata=%h ready=%b want valid=1 rdata=%h ready=0", rsp_valid, rsp_rdata, req_ready, e);
      end
    end
    handshake();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_be_zero();
    int acc, seen, we0;
    logic [31:0] d, e;
    we0 = we_cnt;
    do_req(1'b1, 6'd5, 32'hFFFFFFFF, 4'h0, acc);
    wait_rsp(d, seen);
    e = sb.pop_front();
    checks++; if (d !== e) begin failures++; $display("FAIL be0_rdata got=%h want=%h", d, e); end
    handshake();
    checks++; if (we_cnt != we0) begin failures++; $display("FAIL be0_ram_we got=%0d want=0", we_cnt - we0); end
  endtask

  task automatic test_sweep();
    int acc, seen;
    logic [31:0] d, e;
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      do_req(1'b1, 6'(a), 32'(a), 4'hF, acc);
      wait_rsp(d, seen);
      e = sb.pop_front();
      if (d !== e) bad++;
      handshake();
    end
    for (int a = 0; a < 64; a++) begin
      do_req(1'b0, 6'(a), 32'h0, 4'h0, acc);
      wait_rsp(d, seen);
      e = sb.pop_front();
      checks++; if (d !== e) begin failures++; $display("FAIL sweep_rd addr=%0d got=%h want=%h", a, d, e); end
      handshake();
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL sweep_wr_rsp got=%0d bad want=0", bad); end
  endtask

  task automatic test_reset_mid_wr();
    int acc;
    do_req(1'b1, 6'd10, 32'hA5A5A5A5, 4'hF, acc);
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL mid_wr_we got=%b want=1", ram_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0 || rsp_valid !== 1'b0 || ram_qspo_srst !== 1'b1 || ram_d !== 32'h0) begin
      failures++; $display("FAIL mid_abort got we=%b valid=%b srst=%b d=%h want 0 0 1 0", ram_we, rsp_valid, ram_qspo_srst, ram_d);
    end
    sb.delete();
    ref_mem[10] = 32'd10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem[10] !== 32'd10) begin failures++; $display("FAIL mid_ram_word got=%h want=%h", mem[10], 32'd10); end
    test_read(6'd10, "mid");
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    test_reset();
    test_full_write();
    test_read(6'd5, "r5");
    test_partial_write();
    test_read(6'd5, "r5pw");
    test_backpressure();
    test_be_zero();
    test_read(6'd5, "r5be0");
    test_sweep();
    test_reset_mid_wr();
    checks++; if (overlap_cnt != 0) begin failures++; $display("FAIL we_ce_overlap got=%0d want=0", overlap_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
